// File: rtl/ddr_ctrl_pkg.sv
// Shared types and SDRAM command encodings for the SDRAM controller blocks
// (arbiter, init, refresh, write and read command generators).
package ddr_ctrl_pkg;

   localparam int DDR_ADDR_W = 13;
   localparam int DDR_BA_W   = 2;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_MRS  = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_t;

   typedef struct packed {
      logic [3:0]            cmd;
      logic [DDR_BA_W-1:0]   ba;
      logic [DDR_ADDR_W-1:0] addr;
   } cmd_bus_t;

endpackage

// File: rtl/ddr_ctrl_arbit.sv
// SDRAM command-bus arbiter: holds the bus for init, then grants refresh
// (fixed top priority) or write/read (round-robin) one owner at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | init sequence running, init module drives the pins
// ST_ARBIT | no owner, pins carry NOP, choose next owner
// ST_AREF  | auto-refresh owns the bus until aref_end_i
// ST_WRITE | write module owns the bus and DQ until wr_end_i
// ST_READ  | read module owns the bus until rd_end_i
module ddr_ctrl_arbit
   import ddr_ctrl_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int BA_W   = 2,
   parameter int DATA_W = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              init_end_i,
   input  logic [3:0]        init_cmd_i,
   input  logic [BA_W-1:0]   init_ba_i,
   input  logic [ADDR_W-1:0] init_addr_i,
   input  logic              aref_req_i,
   input  logic              aref_end_i,
   input  logic [3:0]        aref_cmd_i,
   input  logic [BA_W-1:0]   aref_ba_i,
   input  logic [ADDR_W-1:0] aref_addr_i,
   input  logic              wr_req_i,
   input  logic              rd_req_i,
   input  logic              wr_end_i,
   input  logic              rd_end_i,
   input  logic [3:0]        wr_cmd_i,
   input  logic [BA_W-1:0]   wr_ba_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [3:0]        rd_cmd_i,
   input  logic [BA_W-1:0]   rd_ba_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_sdram_en_i,
   input  logic [DATA_W-1:0] wr_sdram_data_i,
   output logic              aref_en_o,
   output logic              wr_en_o,
   output logic              rd_en_o,
   output logic [3:0]        sdram_cmd_o,
   output logic [BA_W-1:0]   sdram_ba_o,
   output logic [ADDR_W-1:0] sdram_addr_o,
   output logic [DATA_W-1:0] sdram_dq_o,
   output logic              sdram_dq_oe_o
);

   typedef struct packed {
      logic [3:0]        cmd;
      logic [BA_W-1:0]   ba;
      logic [ADDR_W-1:0] addr;
   } bus_t;

   state_t state_q, state_d;
   logic   last_wr_q, last_wr_d;
   bus_t   bus;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      case (state_q)
         ST_IDLE:  if (init_end_i) state_d = ST_ARBIT;
         ST_ARBIT: begin
            // Write wins unless read is also waiting and write went last.
            if (aref_req_i) begin
               state_d = ST_AREF;
            end else if (wr_req_i && (!rd_req_i || !last_wr_q)) begin
               state_d   = ST_WRITE;
               last_wr_d = 1'b1;
            end else if (rd_req_i) begin
               state_d   = ST_READ;
               last_wr_d = 1'b0;
            end
         end
         ST_AREF:  if (aref_end_i) state_d = ST_ARBIT;
         ST_WRITE: if (wr_end_i)   state_d = ST_ARBIT;
         ST_READ:  if (rd_end_i)   state_d = ST_ARBIT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus       = '{cmd: CMD_NOP, ba: '1, addr: '1};
      aref_en_o = 1'b0;
      wr_en_o   = 1'b0;
      rd_en_o   = 1'b0;
      case (state_q)
         ST_IDLE:  bus = '{cmd: init_cmd_i, ba: init_ba_i, addr: init_addr_i};
         ST_AREF: begin
            bus       = '{cmd: aref_cmd_i, ba: aref_ba_i, addr: aref_addr_i};
            aref_en_o = 1'b1;
         end
         ST_WRITE: begin
            bus     = '{cmd: wr_cmd_i, ba: wr_ba_i, addr: wr_addr_i};
            wr_en_o = 1'b1;
         end
         ST_READ: begin
            bus     = '{cmd: rd_cmd_i, ba: rd_ba_i, addr: rd_addr_i};
            rd_en_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign sdram_cmd_o   = bus.cmd;
   assign sdram_ba_o    = bus.ba;
   assign sdram_addr_o  = bus.addr;
   assign sdram_dq_oe_o = (state_q == ST_WRITE) && wr_sdram_en_i;
   assign sdram_dq_o    = sdram_dq_oe_o ? wr_sdram_data_i : '0;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// Self-checking bench for ddr_ctrl_arbit: directed scenarios plus randomized
// traffic, all checked against an owner-based reference model.
module tb_ddr_ctrl_arbit;

   localparam int ADDR_W = 13;
   localparam int BA_W   = 2;
   localparam int DATA_W = 16;

   localparam int O_INIT = 0;
   localparam int O_NONE = 1;
   localparam int O_AREF = 2;
   localparam int O_WR   = 3;
   localparam int O_RD   = 4;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic              init_end_i;
   logic [3:0]        init_cmd_i, aref_cmd_i, wr_cmd_i, rd_cmd_i;
   logic [BA_W-1:0]   init_ba_i, aref_ba_i, wr_ba_i, rd_ba_i;
   logic [ADDR_W-1:0] init_addr_i, aref_addr_i, wr_addr_i, rd_addr_i;
   logic              aref_req_i, aref_end_i, wr_req_i, rd_req_i, wr_end_i, rd_end_i;
   logic              wr_sdram_en_i;
   logic [DATA_W-1:0] wr_sdram_data_i;
   logic              aref_en_o, wr_en_o, rd_en_o;
   logic [3:0]        sdram_cmd_o;
   logic [BA_W-1:0]   sdram_ba_o;
   logic [ADDR_W-1:0] sdram_addr_o;
   logic [DATA_W-1:0] sdram_dq_o;
   logic              sdram_dq_oe_o;

   int total = 0;
   int bad   = 0;
   int m_own;
   bit m_last_wr;
   int grants[$];

   ddr_ctrl_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W)) u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end_i(init_end_i),
      .init_cmd_i(init_cmd_i), .init_ba_i(init_ba_i), .init_addr_i(init_addr_i),
      .aref_req_i(aref_req_i), .aref_end_i(aref_end_i),
      .aref_cmd_i(aref_cmd_i), .aref_ba_i(aref_ba_i), .aref_addr_i(aref_addr_i),
      .wr_req_i(wr_req_i), .rd_req_i(rd_req_i), .wr_end_i(wr_end_i), .rd_end_i(rd_end_i),
      .wr_cmd_i(wr_cmd_i), .wr_ba_i(wr_ba_i), .wr_addr_i(wr_addr_i),
      .rd_cmd_i(rd_cmd_i), .rd_ba_i(rd_ba_i), .rd_addr_i(rd_addr_i),
      .wr_sdram_en_i(wr_sdram_en_i), .wr_sdram_data_i(wr_sdram_data_i),
      .aref_en_o(aref_en_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
      .sdram_cmd_o(sdram_cmd_o), .sdram_ba_o(sdram_ba_o), .sdram_addr_o(sdram_addr_o),
      .sdram_dq_o(sdram_dq_o), .sdram_dq_oe_o(sdram_dq_oe_o)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Next owner from the arbitration rules: refresh first, then the
   // write/read side that did not go last, otherwise whoever asks.
   function automatic int model_next();
      case (m_own)
         O_INIT: return init_end_i ? O_NONE : O_INIT;
         O_NONE: begin
            if (aref_req_i)              return O_AREF;
            if (wr_req_i && rd_req_i)    return m_last_wr ? O_RD : O_WR;
            if (wr_req_i)                return O_WR;
            if (rd_req_i)                return O_RD;
            return O_NONE;
         end
         O_AREF: return aref_end_i ? O_NONE : O_AREF;
         O_WR:   return wr_end_i   ? O_NONE : O_WR;
         default: return rd_end_i  ? O_NONE : O_RD;
      endcase
   endfunction

   task automatic check_pins();
      logic [3:0]        e_cmd;
      logic [BA_W-1:0]   e_ba;
      logic [ADDR_W-1:0] e_addr;
      bit                e_oe;
      case (m_own)
         O_INIT: begin e_cmd = init_cmd_i; e_ba = init_ba_i; e_addr = init_addr_i; end
         O_AREF: begin e_cmd = aref_cmd_i; e_ba = aref_ba_i; e_addr = aref_addr_i; end
         O_WR:   begin e_cmd = wr_cmd_i;   e_ba = wr_ba_i;   e_addr = wr_addr_i;   end
         O_RD:   begin e_cmd = rd_cmd_i;   e_ba = rd_ba_i;   e_addr = rd_addr_i;   end
         default: begin e_cmd = 4'b0111; e_ba = '1; e_addr = '1; end
      endcase
      e_oe = (m_own == O_WR) && wr_sdram_en_i;
      check_val("aref_en", 32'(aref_en_o), 32'(m_own == O_AREF));
      check_val("wr_en",   32'(wr_en_o),   32'(m_own == O_WR));
      check_val("rd_en",   32'(rd_en_o),   32'(m_own == O_RD));
      check_val("cmd",     32'(sdram_cmd_o),  32'(e_cmd));
      check_val("ba",      32'(sdram_ba_o),   32'(e_ba));
      check_val("addr",    32'(sdram_addr_o), 32'(e_addr));
      check_val("dq_oe",   32'(sdram_dq_oe_o), 32'(e_oe));
      check_val("dq",      32'(sdram_dq_o), e_oe ? 32'(wr_sdram_data_i) : 32'd0);
   endtask

   // One clock: advance the model at the edge, check at the falling edge.
   task automatic cycle();
      int nxt;
      nxt = model_next();
      @(posedge sys_clk);
      if (m_own == O_NONE && nxt != O_NONE) grants.push_back(nxt);
      if (nxt == O_WR && m_own != O_WR) m_last_wr = 1'b1;
      if (nxt == O_RD && m_own != O_RD) m_last_wr = 1'b0;
      m_own = nxt;
      @(negedge sys_clk);
      aref_end_i = 1'b0;
      wr_end_i   = 1'b0;
      rd_end_i   = 1'b0;
      check_pins();
   endtask

   task automatic rand_buses();
      init_cmd_i  = 4'($urandom); init_ba_i = BA_W'($urandom); init_addr_i = ADDR_W'($urandom);
      aref_cmd_i  = 4'($urandom); aref_ba_i = BA_W'($urandom); aref_addr_i = ADDR_W'($urandom);
      wr_cmd_i    = 4'($urandom); wr_ba_i   = BA_W'($urandom); wr_addr_i   = ADDR_W'($urandom);
      rd_cmd_i    = 4'($urandom); rd_ba_i   = BA_W'($urandom); rd_addr_i   = ADDR_W'($urandom);
      wr_sdram_en_i   = 1'($urandom);
      wr_sdram_data_i = DATA_W'($urandom);
   endtask

   initial begin
      sys_rst = 1'b1;
      init_end_i = 1'b0; aref_req_i = 1'b0; wr_req_i = 1'b0; rd_req_i = 1'b0;
      aref_end_i = 1'b0; wr_end_i = 1'b0; rd_end_i = 1'b0;
      rand_buses();
      init_cmd_i = 4'b0010;
      wr_sdram_en_i = 1'b1;
      m_own = O_INIT; m_last_wr = 1'b0;
      #3;
      check_pins();
      check_val("rst_cmd", 32'(sdram_cmd_o), 32'h2);
      @(negedge sys_clk);
      sys_rst = 1'b0;

      // init phase: pins follow the init bus
      for (int i = 0; i < 20; i++) begin
         init_addr_i = ADDR_W'($urandom);
         cycle();
      end
      check_val("init_cmd", 32'(sdram_cmd_o), 32'h2);
      init_end_i = 1'b1;
      cycle();
      check_val("init_done_nop", 32'(sdram_cmd_o), 32'h7);

      // single read
      rd_req_i = 1'b1; rd_addr_i = 13'h0A5; rd_cmd_i = 4'b0101;
      cycle();
      check_val("rd_grant", 32'(rd_en_o), 32'd1);
      check_val("rd_addr", 32'(sdram_addr_o), 32'h0A5);
      rd_req_i = 1'b0;
      wr_sdram_en_i = 1'b1;
      cycle();
      check_val("rd_no_oe", 32'(sdram_dq_oe_o), 32'd0);
      rd_end_i = 1'b1;
      cycle();
      check_val("rd_release", 32'(rd_en_o), 32'd0);
      check_val("rd_release_nop", 32'(sdram_cmd_o), 32'h7);

      // priority: refresh beats both, then write (read went last)
      aref_req_i = 1'b1; wr_req_i = 1'b1; rd_req_i = 1'b1;
      cycle();
      check_val("prio_aref", 32'({aref_en_o, wr_en_o, rd_en_o}), 32'b100);
      aref_req_i = 1'b0;
      cycle();
      aref_end_i = 1'b1;
      cycle();
      check_val("aref_gap_nop", 32'(sdram_cmd_o), 32'h7);
      grants.delete();
      cycle();
      check_val("after_aref_wr", 32'(wr_en_o), 32'd1);

      // round-robin with both held; DQ drive checks along the way
      wr_sdram_en_i = 1'b1; wr_sdram_data_i = 16'hBEEF;
      cycle();
      check_val("dq_beef", 32'(sdram_dq_o), 32'hBEEF);
      check_val("dq_oe_wr", 32'(sdram_dq_oe_o), 32'd1);
      for (int b = 0; b < 3; b++) begin
         if (wr_en_o) wr_end_i = 1'b1; else rd_end_i = 1'b1;
         cycle();
         check_val("rr_gap_nop", 32'(sdram_cmd_o), 32'h7);
         cycle();
         cycle();
      end
      check_val("rr_count", 32'(grants.size()), 32'd4);
      if (grants.size() == 4) begin
         check_val("rr_0", 32'(grants[0]), 32'(O_WR));
         check_val("rr_1", 32'(grants[1]), 32'(O_RD));
         check_val("rr_2", 32'(grants[2]), 32'(O_WR));
         check_val("rr_3", 32'(grants[3]), 32'(O_RD));
      end
      rd_end_i = 1'b1; wr_req_i = 1'b0; rd_req_i = 1'b0;
      cycle();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         rand_buses();
         if (m_own == O_AREF && aref_req_i) aref_req_i = 1'b0;
         else if (!aref_req_i) aref_req_i = ($urandom_range(0, 19) == 0);
         if (m_own == O_WR) wr_req_i = 1'b0;
         else wr_req_i = wr_req_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
         if (m_own == O_RD) rd_req_i = 1'b0;
         else rd_req_i = rd_req_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
         aref_end_i = (m_own == O_AREF) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         wr_end_i   = (m_own == O_WR)   ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         rd_end_i   = (m_own == O_RD)   ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         if (n % 300 == 150) init_end_i = 1'b0;
         else init_end_i = 1'b1;
         cycle();
      end

      // reset in the middle of a write burst
      aref_req_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0; init_end_i = 1'b1;
      for (int k = 0; k < 20 && m_own != O_NONE; k++) begin
         aref_end_i = 1'b1; wr_end_i = 1'b1; rd_end_i = 1'b1;
         cycle();
      end
      check_val("pre_rst_idle", 32'(m_own), 32'(O_NONE));
      wr_req_i = 1'b1;
      cycle();
      wr_req_i = 1'b0;
      wr_sdram_en_i = 1'b1;
      cycle();
      check_val("pre_rst_wr", 32'(wr_en_o), 32'd1);
      #2 sys_rst = 1'b1;
      m_own = O_INIT; m_last_wr = 1'b0;
      #1;
      check_val("rst_wr_en", 32'(wr_en_o), 32'd0);
      check_val("rst_oe", 32'(sdram_dq_oe_o), 32'd0);
      check_pins();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cycle();
      check_val("post_rst_arbit", 32'(sdram_cmd_o), 32'h7);
      wr_req_i = 1'b1; rd_req_i = 1'b1;
      cycle();
      check_val("post_rst_wr_first", 32'(wr_en_o), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr_ctrl_arbit.md
# ddr_ctrl_arbit

Command-bus arbiter and sequencer for the SDRAM controller. It sits between the four command generators (init, auto-refresh, write, read) and the SDRAM pins. It holds the bus for init until initialisation completes, then grants exclusive bus ownership to one requester at a time:

- Auto-refresh has fixed top priority.
- Write and read requests share the remaining bandwidth round-robin.
- The owner's command, bank and address go to the pins; the write data bus is driven only during write bursts.

## Interface
Parameters:
- ADDR_W, 13, SDRAM row/column address width
- BA_W, 2, bank address width
- DATA_W, 16, SDRAM DQ width

Ports:
- sys_clk  in  1  controller clock; all state changes on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- init_end_i  in  1  init sequence done; level, stays high after first assertion
- init_cmd_i / init_ba_i / init_addr_i  in  4 / BA_W / ADDR_W  init module command bus
- aref_req_i  in  1  refresh due (level, held until granted)
- aref_end_i  in  1  refresh sequence finished (1-cycle pulse)
- aref_cmd_i / aref_ba_i / aref_addr_i  in  4 / BA_W / ADDR_W  refresh command bus
- wr_req_i / rd_req_i  in  1  user write / read request (level, held until granted)
- wr_end_i / rd_end_i  in  1  burst finished (1-cycle pulse)
- wr_cmd_i / wr_ba_i / wr_addr_i  in  4 / BA_W / ADDR_W  write command bus
- rd_cmd_i / rd_ba_i / rd_addr_i  in  4 / BA_W / ADDR_W  read command bus
- wr_sdram_en_i  in  1  write module requests DQ drive
- wr_sdram_data_i  in  DATA_W  write data
- aref_en_o / wr_en_o / rd_en_o  out  1  grant to the corresponding module
- sdram_cmd_o  out  4  {cs_n, ras_n, cas_n, we_n}
- sdram_ba_o  out  BA_W  bank address
- sdram_addr_o  out  ADDR_W  address
- sdram_dq_o  out  DATA_W  write data to pad
- sdram_dq_oe_o  out  1  pad output enable

## Operation
FSM states: IDLE, ARBIT, AREF, WRITE, READ.

Transitions:
- IDLE → ARBIT when init_end_i=1.
- ARBIT priority:
  - aref_req_i → AREF.
  - Otherwise, if both wr and rd are requesting, grant the one not served last. The last_wr flag is set on entry to WRITE and cleared on entry to READ.
  - Otherwise, grant whichever of wr_req_i / rd_req_i is high.
  - Otherwise, stay in ARBIT.
- AREF / WRITE / READ → ARBIT on the matching *_end_i. Other requests are ignored until then; there is no preemption.
- init_end_i dropping after IDLE is ignored.

Outputs:
- Grant outputs are decoded from state: aref_en_o=(state==AREF), wr_en_o=(state==WRITE), rd_en_o=(state==READ). They are mutually exclusive.
- Command/bank/address mux (combinational from state):
  - IDLE: init bus.
  - AREF / WRITE / READ: the owner's bus.
  - ARBIT: NOP, i.e. cmd=4'b0111, ba={BA_W{1'b1}}, addr={ADDR_W{1'b1}}.
- sdram_dq_oe_o = (state==WRITE) & wr_sdram_en_i. sdram_dq_o = wr_sdram_data_i when oe=1, otherwise 0.

Reset (async, any time, including mid-burst):
- state=IDLE, last_wr=0, all *_en_o=0.
- The bus carries the init inputs. The init module holds NOP during its own reset.
- sdram_dq_oe_o=0, sdram_dq_o=0.

## Timing
- Grant latency: a request seen in ARBIT at edge N gives state and *_en_o high from edge N onward. ARBIT occupies ≥1 cycle between any two grants, so the pins show ≥1 NOP cycle between owners.
- Release: *_end_i high sampled at edge M leaves state=ARBIT after M. en drops in the same cycle as the state change.
- *_end_i arriving in a non-matching state is ignored.
- Simultaneous aref_req_i, wr_req_i and rd_req_i in ARBIT: AREF wins. After AREF ends, round-robin resolves wr/rd.
- A request that drops before grant is not remembered.
- Worst-case read/write wait: one refresh plus one opposing burst.

## Structure
Package ddr_ctrl_pkg holds:
- the state enum,
- command localparams (CMD_NOP=4'b0111, CMD_PRE, CMD_AREF, CMD_ACT, CMD_WR, CMD_RD, CMD_MRS),
- a cmd-bus struct {cmd, ba, addr}.

ddr_ctrl_rd, ddr_ctrl_wr and ddr_ctrl_aref import the same package. The block is a single module with no sub-modules; the mux is a case on state.

## Test plan
- Reset then init: hold init_end_i=0 for 20 cycles with init_cmd_i=4'b0010 → pins follow init bus. Raise init_end_i → state ARBIT next edge, sdram_cmd_o=4'b0111.
- Single read: rd_req_i=1, rd_addr_i=13'h0A5, rd_cmd_i=4'b0101 → rd_en_o high the cycle after the request is sampled, pins mirror the rd bus. rd_end_i pulse → rd_en_o low next edge, pins NOP.
- Priority: aref_req_i, wr_req_i and rd_req_i all high in ARBIT → aref_en_o only. After aref_end_i, one NOP cycle, then wr_en_o (last_wr=0 after reset).
- Round-robin: wr and rd held high continuously for 4 bursts → grant order WRITE, READ, WRITE, READ, with a NOP cycle between each.
- DQ drive: in WRITE with wr_sdram_en_i=1 and data 16'hBEEF → sdram_dq_oe_o=1, dq=16'hBEEF. In READ with wr_sdram_en_i=1 → oe=0.
- Reset mid-write: assert sys_rst asynchronously between edges → wr_en_o and oe drop immediately, state IDLE. After release, init_end_i still high → ARBIT on the next edge.
